regfile_port_arbiter: RTL

Shares a small 16-bit register bank between one read requester and two write requesters (port 1, port 2) with a per-port req/gnt handshake. At most one access is granted per cycle. Reads normally have priority. The two write ports alternate round-robin. A streak limiter prevents reads from starving writers. The block sits between the datapath's register storage and the units that load and observe it.

---
 rtl/regfile_port_arbiter_pkg.sv | 21 ++
 rtl/regfile_bank.sv | 44 ++++
 rtl/regfile_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared types and constants for the register-bank port arbiter
// Purpose: arbiter state encoding, default bank geometry, round-robin port indices.
package regfile_port_arbiter_pkg;

    localparam int DATA_W_DEF          = 16;
    localparam int ADDR_W_DEF          = 2;
    localparam int MAX_READ_STREAK_DEF = 3;

    // Round-robin pointer values: which write port is preferred next.
    localparam logic PORT1 = 1'b0;
    localparam logic PORT2 = 1'b1;

    // Grant issued at the most recent clock edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE1 = 2'd2,
        WRITE2 = 2'd3
    } arb_state_t;

endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - register storage with one write port and one registered read port
// Purpose: 2**ADDR_W x DATA_W register bank, asynchronously cleared.
// Ports:
//   clk, reset        clock, asynchronous active-high clear of storage and read data
//   wr_en/addr/data   synchronous write, committed at the rising edge
//   rd_en/addr        registered read request
//   rd_data           read result, holds until the next read
module regfile_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            // The arbiter never enables both in one cycle, so a read sees only
            // values committed at earlier edges.
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - one-read / two-write arbiter in front of a small register bank
// Purpose: grants at most one bank access per cycle; reads first, writes round-robin,
//          read streak limited while a write waits.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rd_req/rd_addr -> rd_gnt        read handshake
//   rd_data, rd_valid               read result, valid with rd_gnt
//   wr1_req/addr/data -> wr1_gnt    write port 1 handshake
//   wr2_req/addr/data -> wr2_gnt    write port 2 handshake
//   busy                            a request is pending and nothing is granted
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int MAX_READ_STREAK = MAX_READ_STREAK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    input  logic              wr2_req,
    input  logic [ADDR_W-1:0] wr2_addr,
    input  logic [DATA_W-1:0] wr2_data,
    output logic              wr2_gnt,
    output logic              busy
);

    localparam int                STREAK_W   = $clog2(MAX_READ_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

    arb_state_t          state;
    arb_state_t          state_next;
    logic                rr_ptr;
    logic [STREAK_W-1:0] streak;

    logic                rd_elig;
    logic                wr1_elig;
    logic                wr2_elig;
    logic                pref_elig;
    logic                other_elig;
    arb_state_t          pref_state;
    arb_state_t          other_state;

    logic                bank_wr_en;
    logic [ADDR_W-1:0]   bank_wr_addr;
    logic [DATA_W-1:0]   bank_wr_data;
    logic                bank_rd_en;

    // A requester granted at the last edge sits out one decision so a held
    // req is not granted twice while the requester drops it.
    always_comb begin
        rd_elig     = rd_req  && (state != READ);
        wr1_elig    = wr1_req && (state != WRITE1);
        wr2_elig    = wr2_req && (state != WRITE2);
        pref_elig   = (rr_ptr == PORT1) ? wr1_elig : wr2_elig;
        other_elig  = (rr_ptr == PORT1) ? wr2_elig : wr1_elig;
        pref_state  = (rr_ptr == PORT1) ? WRITE1 : WRITE2;
        other_state = (rr_ptr == PORT1) ? WRITE2 : WRITE1;

        state_next = IDLE;
        if ((streak == STREAK_MAX) && (wr1_elig || wr2_elig)) begin
            state_next = pref_elig ? pref_state : other_state;
        end else if (rd_elig) begin
            state_next = READ;
        end else if (pref_elig) begin
            state_next = pref_state;
        end else if (other_elig) begin
            state_next = other_state;
        end
    end

    // Bank accesses happen at the decision edge; the grant shows the cycle after.
    always_comb begin
        bank_wr_en   = (state_next == WRITE1) || (state_next == WRITE2);
        bank_wr_addr = (state_next == WRITE2) ? wr2_addr : wr1_addr;
        bank_wr_data = (state_next == WRITE2) ? wr2_data : wr1_data;
        bank_rd_en   = (state_next == READ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= PORT1;
            streak   <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= (state_next == READ);

            if (state_next == WRITE1) begin
                rr_ptr <= PORT2;
            end else if (state_next == WRITE2) begin
                rr_ptr <= PORT1;
            end

            if (bank_wr_en || !(wr1_req || wr2_req)) begin
                streak <= '0;
            end else if ((state_next == READ) && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end

    assign rd_gnt  = (state == READ);
    assign wr1_gnt = (state == WRITE1);
    assign wr2_gnt = (state == WRITE2);
    assign busy    = (rd_req | wr1_req | wr2_req) & ~(rd_gnt | wr1_gnt | wr2_gnt);

    regfile_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_wr_en),
        .wr_addr (bank_wr_addr),
        .wr_data (bank_wr_data),
        .rd_en   (bank_rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
